frame_reader: RTL and testbench

- Reader-side counterpart of the 28x28 write-back controller.
- Waits for the controller's `start` pulse, which marks write-back complete.
- Then reads the square frame out of the same single-port RAM in raster order (address +1 per pixel).
- Streams pixels to downstream logic over a valid/ready interface with line/frame markers, and pulses `done` when the last pixel is accepted.

---
 rtl/frame_reader_if.sv | 30 +++
 rtl/frame_reader.sv | 137 +++++++++++++
 tb/tb_frame_reader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_reader_if.sv
// Bus bundle for frame_reader: RAM read port plus pixel stream.
// master = reader side, slave = RAM model / downstream consumer.
interface frame_reader_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_sol;
    logic          pix_eol;
    logic          pix_eof;

    modport master (
        output mem_addr, mem_rd_en,
        input  mem_rdata,
        output pix_data, pix_valid, pix_sol, pix_eol, pix_eof,
        input  pix_ready
    );

    modport slave (
        input  mem_addr, mem_rd_en,
        output mem_rdata,
        input  pix_data, pix_valid, pix_sol, pix_eol, pix_eof,
        output pix_ready
    );
endinterface

// File: rtl/frame_reader.sv
// Reads a square frame from single-port RAM in raster order and streams
// it out over valid/ready with sol/eol/eof markers through a 2-entry FIFO.
module frame_reader #(
    parameter int MAX_DIM   = 28,
    parameter int AW        = 16,
    parameter int DW        = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [8:0] dim,
    output logic       busy,
    output logic       done,
    frame_reader_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [8:0]    edge_q;
    logic [8:0]    row;
    logic [8:0]    col;
    logic [AW-1:0] addr;
    logic          inflight;
    logic [2:0]    meta;
    logic [DW+2:0] fifo [2];
    logic          wp;
    logic          rp;
    logic [1:0]    occ;

    logic [8:0]    e_in;
    logic [8:0]    e_m1;
    logic [2:0]    credit;
    logic [DW+2:0] head;
    logic          valid;
    logic          pop;
    logic          issue;
    logic          last;

    // Edge clamp, read credit and head-of-FIFO decode
    always_comb begin
        e_in   = (dim > 9'(MAX_DIM)) ? 9'(MAX_DIM) : dim;
        e_m1   = edge_q - 9'd1;
        valid  = (occ != 2'd0);
        pop    = valid && bus.pix_ready;
        credit = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
        issue  = (state == S_SCAN) && (credit < 3'd2);
        last   = (row == e_m1) && (col == e_m1);
        head   = fifo[rp];
    end

    // Output drive; stream outputs are forced low when the FIFO is empty
    always_comb begin
        bus.mem_addr  = addr;
        bus.mem_rd_en = issue;
        bus.pix_valid = valid;
        bus.pix_data  = valid ? head[DW+2:3] : '0;
        bus.pix_sol   = valid && head[2];
        bus.pix_eol   = valid && head[1];
        bus.pix_eof   = valid && head[0];
        busy          = (state == S_SCAN) || (state == S_DRAIN);
        done          = (state == S_DONE);
    end

    // Frame control and read-side raster counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            edge_q <= '0;
            row    <= '0;
            col    <= '0;
            addr   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && dim != 9'd0) begin
                        edge_q <= e_in;
                        row    <= '0;
                        col    <= '0;
                        addr   <= AW'(BASE_ADDR);
                        state  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (issue) begin
                        if (last) begin
                            state <= S_DRAIN;
                        end else begin
                            addr <= addr + AW'(1);
                            if (col == e_m1) begin
                                col <= '0;
                                row <= row + 9'd1;
                            end else begin
                                col <= col + 9'd1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && head[0]) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Track the read in flight and the markers computed when it issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            meta     <= '0;
        end else begin
            inflight <= issue;
            if (issue) meta <= {col == 9'd0, col == e_m1, last};
        end
    end

    // Two-entry output FIFO: capture returning data, pop on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) fifo[i] <= '0;
            wp  <= 1'b0;
            rp  <= 1'b0;
            occ <= '0;
        end else begin
            if (inflight) begin
                fifo[wp] <= {bus.mem_rdata, meta};
                wp       <= ~wp;
            end
            if (pop) rp <= ~rp;
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_frame_reader.sv
// Randomized bench for frame_reader: RAM model, raster reference
// model of the expected beat stream, latency and handshake checks.
module tb_frame_reader;
    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int MAXD = 28;
    localparam int BASE = 0;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [8:0] dim   = '0;
    logic       busy;
    logic       done;

    frame_reader_if #(.AW(AW), .DW(DW)) bus ();

    frame_reader #(
        .MAX_DIM(MAXD), .AW(AW), .DW(DW), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dim(dim),
        .busy(busy),
        .done(done),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: one-cycle read latency, content = low address byte
    always @(posedge clk)
        if (bus.mem_rd_en) bus.mem_rdata <= bus.mem_addr[7:0];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(string tag, longint got, longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    int            exp_e;
    int            rd_idx;
    int            beat_idx;
    int            done_cnt;
    int            busy_cnt;
    int            t_start;
    int            t_eof;
    bit            seen_valid;
    bit            fixed_ready = 1'b1;
    bit            prev_stall;
    logic [DW+2:0] prev_out;
    logic [AW-1:0] last_addr;

    function automatic logic [DW+2:0] exp_beat(int k, int e);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = AW'(BASE + k);
        d = a[DW-1:0];
        return {d, k % e == 0, k % e == e - 1, k == e * e - 1};
    endfunction

    task automatic begin_frame(int d);
        exp_e      = (d > MAXD) ? MAXD : d;
        rd_idx     = 0;
        beat_idx   = 0;
        done_cnt   = 0;
        busy_cnt   = 0;
        t_eof      = -10;
        seen_valid = 1'b0;
    endtask

    // Monitor: sampled on the falling edge, compared to the raster model
    always @(negedge clk) begin
        logic [DW+2:0] cur;
        cur = {bus.pix_data, bus.pix_sol, bus.pix_eol, bus.pix_eof};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (prev_stall) check("hold", cur, prev_out);
            prev_stall = bus.pix_valid && !bus.pix_ready;
            prev_out   = cur;
            if (bus.mem_rd_en) begin
                if (rd_idx == 0) check("rd_lat", cyc, t_start);
                check("addr", bus.mem_addr, BASE + rd_idx);
                last_addr = bus.mem_addr;
                rd_idx++;
            end
            if (bus.pix_valid && !seen_valid) begin
                seen_valid = 1'b1;
                check("pix_lat", cyc, t_start + 2);
            end
            if (bus.pix_valid && bus.pix_ready) begin
                if (exp_e == 0) check("beat_unexp", 1, 0);
                else check("beat", cur, exp_beat(beat_idx, exp_e));
                if (bus.pix_eof) begin
                    t_eof = cyc;
                    if (fixed_ready)
                        check("t_last", cyc, t_start + 1 + exp_e * exp_e);
                end
                beat_idx++;
            end
            check("credit", (rd_idx - beat_idx) <= 2, 1);
            if (done) begin
                done_cnt++;
                check("done_lat", cyc, t_eof + 1);
            end
        end
    end

    // Downstream ready: held high or toggled pseudo-randomly
    initial begin
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.pix_ready = fixed_ready ? 1'b1 : 1'($urandom % 2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(int d);
        start   = 1'b1;
        dim     = 9'(d);
        t_start = cyc + 1;
        tick();
        start = 1'b0;
        dim   = 9'($urandom);
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == 0) check("timeout", 0, 1);
    endtask

    task automatic run_frame(int d, bit fixed, bit extra);
        int t_done;
        fixed_ready = fixed;
        begin_frame(d);
        tick();
        pulse_start(d);
        t_done = t_start + 2 + exp_e * exp_e;
        if (extra) begin
            repeat (40) tick();
            start = 1'b1;
            dim   = 9'd5;
            tick();
            start = 1'b0;
            while (cyc < t_done) tick();
            start = 1'b1;
            dim   = 9'd3;
            tick();
            start = 1'b0;
        end
        wait_done(20000);
        repeat (30) tick();
        check("beats", beat_idx, exp_e * exp_e);
        check("reads", rd_idx, exp_e * exp_e);
        check("done_cnt", done_cnt, 1);
        check("last_addr", last_addr, BASE + exp_e * exp_e - 1);
        check("busy_end", busy, 0);
        if (fixed && done_cnt == 1)
            check("t_done", t_eof + 1, t_done);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_out",
              {bus.mem_addr, bus.mem_rd_en, bus.pix_data, bus.pix_valid,
               bus.pix_sol, bus.pix_eol, bus.pix_eof, busy, done}, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        run_frame(28, 1'b1, 1'b0);
        run_frame(28, 1'b0, 1'b0);
        run_frame(1, 1'b1, 1'b0);

        fixed_ready = 1'b1;
        begin_frame(0);
        pulse_start(0);
        repeat (20) tick();
        check("dim0_reads", rd_idx, 0);
        check("dim0_done", done_cnt, 0);
        check("dim0_busy", busy_cnt, 0);

        run_frame(40, 1'b1, 1'b0);

        begin
            int n = 0;
            fixed_ready = 1'b0;
            begin_frame(28);
            tick();
            pulse_start(28);
            while (beat_idx < 300 && n < 5000) begin
                tick();
                n++;
            end
            check("reach_300", beat_idx >= 300, 1);
            rst_n = 1'b0;
            #1;
            check("rst_mid_out",
                  {bus.mem_addr, bus.mem_rd_en, bus.pix_data,
                   bus.pix_valid, bus.pix_sol, bus.pix_eol, bus.pix_eof,
                   busy, done}, 0);
            tick();
            rst_n = 1'b1;
            repeat (30) tick();
            check("rst_nodone", done_cnt, 0);
            check("rst_idle", busy, 0);
        end

        run_frame(28, 1'b1, 1'b0);
        run_frame(28, 1'b1, 1'b1);

        for (int i = 0; i < 4; i++)
            run_frame(int'($urandom_range(1, 35)), 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
